// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter. Display fetches always own the RAM port.
// A one-entry posted write buffer absorbs CPU writes; CPU reads use idle slots.
module vga_fb_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 12
) (
    input  logic              clk_25mhz,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wbuf_full,
    output logic [7:0]        stall_cnt
);

    typedef enum logic [1:0] {IDLE, RD_ISSUED, ACK} cpu_state_t;

    cpu_state_t        state_reg, state_next;
    logic              wbuf_full_reg, wbuf_full_next;
    logic [ADDR_W-1:0] wbuf_addr_reg, wbuf_addr_next;
    logic [DATA_W-1:0] wbuf_data_reg, wbuf_data_next;
    logic [DATA_W-1:0] cpu_rdata_reg, cpu_rdata_next;
    logic              vga_rvalid_reg;
    logic [7:0]        stall_cnt_reg, stall_cnt_next;

    logic drain;
    logic wr_accept;
    logic rd_forward;
    logic rd_issue;
    logic stall;

    always_comb begin
        drain          = wbuf_full_reg && !vga_req;
        wr_accept      = 1'b0;
        rd_forward     = 1'b0;
        rd_issue       = 1'b0;
        stall          = 1'b0;
        state_next     = state_reg;
        cpu_rdata_next = cpu_rdata_reg;

        case (state_reg)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        // A draining buffer frees its slot at the same edge.
                        if (!wbuf_full_reg || drain) wr_accept = 1'b1;
                        else                         stall     = 1'b1;
                    end else if (wbuf_full_reg && cpu_addr == wbuf_addr_reg) begin
                        rd_forward = 1'b1;
                    end else if (!vga_req && !wbuf_full_reg) begin
                        rd_issue = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end
                if (wr_accept || rd_forward) state_next = ACK;
                if (rd_issue)                state_next = RD_ISSUED;
                if (rd_forward)              cpu_rdata_next = wbuf_data_reg;
            end
            RD_ISSUED: begin
                cpu_rdata_next = mem_rdata;
                state_next     = ACK;
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        wbuf_full_next = wbuf_full_reg;
        wbuf_addr_next = wbuf_addr_reg;
        wbuf_data_next = wbuf_data_reg;
        if (wr_accept) begin
            wbuf_full_next = 1'b1;
            wbuf_addr_next = cpu_addr;
            wbuf_data_next = cpu_wdata;
        end else if (drain) begin
            wbuf_full_next = 1'b0;
        end

        stall_cnt_next = stall_cnt_reg;
        if (stall && stall_cnt_reg != 8'hFF) stall_cnt_next = stall_cnt_reg + 8'd1;
    end

    // Port mux: display fetch, then buffer drain, then CPU read.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset) begin
            if (vga_req) begin
                mem_en   = 1'b1;
                mem_addr = vga_addr;
            end else if (wbuf_full_reg) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wbuf_addr_reg;
                mem_wdata = wbuf_data_reg;
            end else if (rd_issue) begin
                mem_en   = 1'b1;
                mem_addr = cpu_addr;
            end
        end
    end

    always_ff @(posedge clk_25mhz or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            wbuf_full_reg  <= 1'b0;
            wbuf_addr_reg  <= '0;
            wbuf_data_reg  <= '0;
            cpu_rdata_reg  <= '0;
            vga_rvalid_reg <= 1'b0;
            stall_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            wbuf_full_reg  <= wbuf_full_next;
            wbuf_addr_reg  <= wbuf_addr_next;
            wbuf_data_reg  <= wbuf_data_next;
            cpu_rdata_reg  <= cpu_rdata_next;
            vga_rvalid_reg <= vga_req;
            stall_cnt_reg  <= stall_cnt_next;
        end
    end

    assign vga_rvalid = vga_rvalid_reg;
    assign vga_rdata  = vga_rvalid_reg ? mem_rdata : '0;
    assign cpu_ack    = (state_reg == ACK);
    assign cpu_rdata  = cpu_rdata_reg;
    assign wbuf_full  = wbuf_full_reg;
    assign stall_cnt  = stall_cnt_reg;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios plus randomized traffic checked
// against a shadow memory and a registered-read RAM model.
module tb_vga_fb_arbiter;
    localparam int AW = 9;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          vga_req, cpu_req, cpu_we;
    logic [AW-1:0] vga_addr, cpu_addr, mem_addr;
    logic [DW-1:0] vga_rdata, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
    logic          vga_rvalid, cpu_ack, mem_en, mem_we, wbuf_full;
    logic [7:0]    stall_cnt;

    logic [DW-1:0] ram [0:511];
    logic [DW-1:0] ram_q;
    bit            ram_ready;
    logic [DW-1:0] shadow [0:511];
    int            wr_log_addr[$];
    int            wr_log_data[$];
    int            tests = 0;
    int            fails = 0;
    int            exp_stall = 0;

    always #20 clk = ~clk;

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_25mhz(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .wbuf_full(wbuf_full), .stall_cnt(stall_cnt)
    );

    function automatic logic [DW-1:0] init_word(int i);
        if (i == 'h30) return 12'h0F0;
        return 12'((i * 37 + 5) % 4096);
    endfunction

    // Single-port RAM model with one-cycle registered read.
    assign mem_rdata = ram_q;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 512; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_log_addr.push_back(int'(mem_addr));
            wr_log_data.push_back(int'(mem_wdata));
        end else if (mem_en) begin
            ram_q <= ram[mem_addr];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; vga_req = 1'b1; vga_addr = 9'd3;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'd3; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if ({mem_en, mem_we} !== 2'b00) begin fails++; $display("FAIL reset_mem: en/we=%b exp 00", {mem_en, mem_we}); end
        tests++; if ({cpu_ack, vga_rvalid, wbuf_full} !== 3'b000) begin fails++; $display("FAIL reset_flags: ack/rvalid/full=%b exp 000", {cpu_ack, vga_rvalid, wbuf_full}); end
        tests++; if (cpu_rdata !== 12'h000) begin fails++; $display("FAIL reset_cpu_rdata: got %h exp 000", cpu_rdata); end
        tests++; if (vga_rdata !== 12'h000) begin fails++; $display("FAIL reset_vga_rdata: got %h exp 000", vga_rdata); end
        tests++; if (stall_cnt !== 8'd0) begin fails++; $display("FAIL reset_stall: got %0d exp 0", stall_cnt); end
        vga_req = 1'b0; cpu_req = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        tests++; if ({mem_en, mem_we, cpu_ack} !== 3'b000) begin fails++; $display("FAIL idle_grant: en/we/ack=%b exp 000", {mem_en, mem_we, cpu_ack}); end
        next_cycle();
        $display("[TB] reset checks done");
    endtask

    task automatic test_vga_burst();
        int wr_before = wr_log_addr.size();
        vga_req = 1'b1;
        for (int i = 0; i < 640; i++) begin
            vga_addr = 9'(i % 512);
            if (i == 10) begin cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h1F0; cpu_wdata = 12'h5A5; end
            @(negedge clk);
            tests++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, vga_addr}) begin fails++; $display("FAIL burst_port[%0d]: en/we/addr=%b/%b/%h exp 1/0/%h", i, mem_en, mem_we, mem_addr, vga_addr); end
            if (i > 0) begin
                tests++; if (vga_rvalid !== 1'b1 || vga_rdata !== init_word((i - 1) % 512)) begin fails++; $display("FAIL burst_data[%0d]: valid=%b data=%h exp 1 %h", i, vga_rvalid, vga_rdata, init_word((i - 1) % 512)); end
            end
            if (i == 10) begin tests++; if (cpu_ack !== 1'b0) begin fails++; $display("FAIL burst_early_ack: got %b exp 0", cpu_ack); end end
            if (i == 11) begin tests++; if ({cpu_ack, wbuf_full} !== 2'b11) begin fails++; $display("FAIL burst_wr_ack: ack/full=%b exp 11", {cpu_ack, wbuf_full}); end end
            if (i == 639) begin tests++; if (wbuf_full !== 1'b1) begin fails++; $display("FAIL burst_held: full=%b exp 1", wbuf_full); end end
            next_cycle();
            if (i == 11) cpu_req = 1'b0;
        end
        tests++; if (wr_log_addr.size() !== wr_before) begin fails++; $display("FAIL burst_no_write: writes=%0d exp %0d", wr_log_addr.size(), wr_before); end
        shadow['h1F0] = 12'h5A5;
        vga_req = 1'b0;
        @(negedge clk);
        tests++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 9'h1F0, 12'h5A5}) begin fails++; $display("FAIL burst_drain: en/we/addr/data=%b/%b/%h/%h exp 1/1/1f0/5a5", mem_en, mem_we, mem_addr, mem_wdata); end
        tests++; if (vga_rvalid !== 1'b1 || vga_rdata !== init_word(127)) begin fails++; $display("FAIL burst_last: valid=%b data=%h exp 1 %h", vga_rvalid, vga_rdata, init_word(127)); end
        next_cycle();
        @(negedge clk);
        tests++; if ({wbuf_full, vga_rvalid} !== 2'b00) begin fails++; $display("FAIL burst_end: full/rvalid=%b exp 00", {wbuf_full, vga_rvalid}); end
        next_cycle();
        $display("[TB] vga burst 640 words done");
    endtask

    task automatic test_write_basic();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h005; cpu_wdata = 12'hABC;
        @(negedge clk);
        tests++; if ({cpu_ack, mem_en} !== 2'b00) begin fails++; $display("FAIL wr_n: ack/en=%b exp 00", {cpu_ack, mem_en}); end
        next_cycle();
        @(negedge clk);
        tests++; if ({cpu_ack, wbuf_full} !== 2'b11) begin fails++; $display("FAIL wr_ack: ack/full=%b exp 11", {cpu_ack, wbuf_full}); end
        tests++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 9'h005, 12'hABC}) begin fails++; $display("FAIL wr_drain: en/we/addr/data=%b/%b/%h/%h exp 1/1/005/abc", mem_en, mem_we, mem_addr, mem_wdata); end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        tests++; if ({cpu_ack, wbuf_full} !== 2'b00) begin fails++; $display("FAIL wr_n2: ack/full=%b exp 00", {cpu_ack, wbuf_full}); end
        tests++; if (stall_cnt !== 8'(exp_stall)) begin fails++; $display("FAIL wr_stall: got %0d exp %0d", stall_cnt, exp_stall); end
        shadow['h005] = 12'hABC;
        next_cycle();
        $display("[TB] cpu wr addr=005 data=abc");
    endtask

    task automatic test_write_stall();
        int wr_before;
        vga_req = 1'b1; vga_addr = 9'($urandom_range(511));
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h010; cpu_wdata = 12'h111;
        @(negedge clk);
        next_cycle();
        vga_addr = 9'($urandom_range(511));
        @(negedge clk);
        tests++; if (cpu_ack !== 1'b1) begin fails++; $display("FAIL ws_ack1: got %b exp 1", cpu_ack); end
        next_cycle();
        cpu_addr = 9'h011; cpu_wdata = 12'h222;
        for (int k = 0; k < 5; k++) begin
            vga_addr = 9'($urandom_range(511));
            @(negedge clk);
            tests++; if ({cpu_ack, mem_we} !== 2'b00 || stall_cnt !== 8'(exp_stall)) begin fails++; $display("FAIL ws_stall[%0d]: ack/we=%b cnt=%0d exp 00 %0d", k, {cpu_ack, mem_we}, stall_cnt, exp_stall); end
            exp_stall++;
            next_cycle();
        end
        vga_req = 1'b0;
        wr_before = wr_log_addr.size();
        @(negedge clk);
        tests++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 9'h010, 12'h111} || stall_cnt !== 8'(exp_stall)) begin fails++; $display("FAIL ws_drain1: we/addr/data=%b/%h/%h cnt=%0d exp 1/010/111 %0d", mem_we, mem_addr, mem_wdata, stall_cnt, exp_stall); end
        next_cycle();
        @(negedge clk);
        tests++; if ({cpu_ack, wbuf_full, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 1'b1, 9'h011, 12'h222}) begin fails++; $display("FAIL ws_ack2: ack/full/we/addr/data=%b/%b/%b/%h/%h exp 1/1/1/011/222", cpu_ack, wbuf_full, mem_we, mem_addr, mem_wdata); end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        tests++; if (wbuf_full !== 1'b0 || stall_cnt !== 8'(exp_stall)) begin fails++; $display("FAIL ws_end: full=%b cnt=%0d exp 0 %0d", wbuf_full, stall_cnt, exp_stall); end
        tests++;
        if (wr_log_addr.size() != wr_before + 2) begin
            fails++; $display("FAIL ws_order: writes=%0d exp %0d", wr_log_addr.size() - wr_before, 2);
        end else if (wr_log_addr[wr_before] != 'h010 || wr_log_data[wr_before] != 'h111 ||
                     wr_log_addr[wr_before + 1] != 'h011 || wr_log_data[wr_before + 1] != 'h222) begin
            fails++; $display("FAIL ws_order: got %h=%h,%h=%h exp 010=111,011=222", wr_log_addr[wr_before], wr_log_data[wr_before], wr_log_addr[wr_before + 1], wr_log_data[wr_before + 1]);
        end
        shadow['h010] = 12'h111; shadow['h011] = 12'h222;
        next_cycle();
        $display("[TB] cpu wr 010=111, wr 011=222 (stalled 5)");
    endtask

    task automatic test_forward();
        vga_req = 1'b1; vga_addr = 9'($urandom_range(511));
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h020; cpu_wdata = 12'h3C3;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        tests++; if (cpu_ack !== 1'b1) begin fails++; $display("FAIL fw_wr_ack: got %b exp 1", cpu_ack); end
        next_cycle();
        cpu_we = 1'b0; vga_addr = 9'($urandom_range(511));
        @(negedge clk);
        tests++; if ({cpu_ack, mem_we, mem_addr} !== {1'b0, 1'b0, vga_addr}) begin fails++; $display("FAIL fw_n: ack/we/addr=%b/%b/%h exp 0/0/%h", cpu_ack, mem_we, mem_addr, vga_addr); end
        next_cycle();
        vga_addr = 9'($urandom_range(511));
        @(negedge clk);
        tests++; if ({cpu_ack, cpu_rdata} !== {1'b1, 12'h3C3}) begin fails++; $display("FAIL fw_ack: ack/rdata=%b/%h exp 1/3c3", cpu_ack, cpu_rdata); end
        tests++; if (mem_addr !== vga_addr || stall_cnt !== 8'(exp_stall)) begin fails++; $display("FAIL fw_port: addr=%h cnt=%0d exp %h %0d", mem_addr, stall_cnt, vga_addr, exp_stall); end
        next_cycle();
        cpu_req = 1'b0; vga_req = 1'b0;
        @(negedge clk);
        tests++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 9'h020, 12'h3C3}) begin fails++; $display("FAIL fw_drain: we/addr/data=%b/%h/%h exp 1/020/3c3", mem_we, mem_addr, mem_wdata); end
        shadow['h020] = 12'h3C3;
        next_cycle();
        $display("[TB] cpu wr 020=3c3, rd 020 -> %h (forwarded)", cpu_rdata);
    endtask

    task automatic test_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h030;
        @(negedge clk);
        tests++; if ({mem_en, mem_we, mem_addr, cpu_ack} !== {1'b1, 1'b0, 9'h030, 1'b0}) begin fails++; $display("FAIL rd_issue: en/we/addr/ack=%b/%b/%h/%b exp 1/0/030/0", mem_en, mem_we, mem_addr, cpu_ack); end
        next_cycle();
        @(negedge clk);
        tests++; if ({cpu_ack, mem_en} !== 2'b00) begin fails++; $display("FAIL rd_n1: ack/en=%b exp 00", {cpu_ack, mem_en}); end
        next_cycle();
        @(negedge clk);
        tests++; if ({cpu_ack, cpu_rdata} !== {1'b1, 12'h0F0}) begin fails++; $display("FAIL rd_ack: ack/rdata=%b/%h exp 1/0f0", cpu_ack, cpu_rdata); end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        tests++; if ({cpu_ack, cpu_rdata} !== {1'b0, 12'h0F0}) begin fails++; $display("FAIL rd_hold: ack/rdata=%b/%h exp 0/0f0", cpu_ack, cpu_rdata); end
        next_cycle();
        $display("[TB] cpu rd 030 -> %h", cpu_rdata);
        // Read blocked by three display fetches, then issued.
        vga_req = 1'b1; cpu_req = 1'b1; cpu_addr = 9'h031;
        for (int k = 0; k < 3; k++) begin
            vga_addr = 9'($urandom_range(511));
            @(negedge clk);
            tests++; if (cpu_ack !== 1'b0 || mem_addr !== vga_addr || stall_cnt !== 8'(exp_stall)) begin fails++; $display("FAIL rdc_stall[%0d]: ack=%b addr=%h cnt=%0d exp 0 %h %0d", k, cpu_ack, mem_addr, stall_cnt, vga_addr, exp_stall); end
            exp_stall++;
            next_cycle();
        end
        vga_req = 1'b0;
        @(negedge clk);
        tests++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 9'h031} || stall_cnt !== 8'(exp_stall)) begin fails++; $display("FAIL rdc_issue: en/we/addr=%b/%b/%h cnt=%0d exp 1/0/031 %0d", mem_en, mem_we, mem_addr, stall_cnt, exp_stall); end
        next_cycle();
        next_cycle();
        @(negedge clk);
        tests++; if ({cpu_ack, cpu_rdata} !== {1'b1, shadow['h031]}) begin fails++; $display("FAIL rdc_ack: ack/rdata=%b/%h exp 1/%h", cpu_ack, cpu_rdata, shadow['h031]); end
        next_cycle();
        cpu_req = 1'b0;
        $display("[TB] cpu rd 031 -> %h (stalled 3)", cpu_rdata);
    endtask

    task automatic test_stall_saturate();
        int e;
        vga_req = 1'b1; vga_addr = 9'h100;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h060; cpu_wdata = 12'h606;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        tests++; if (cpu_ack !== 1'b1) begin fails++; $display("FAIL sat_ack1: got %b exp 1", cpu_ack); end
        next_cycle();
        cpu_addr = 9'h061; cpu_wdata = 12'h616;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            e = (exp_stall > 255) ? 255 : exp_stall;
            tests++; if (stall_cnt !== 8'(e)) begin fails++; $display("FAIL sat_cnt[%0d]: got %0d exp %0d", k, stall_cnt, e); end
            exp_stall++;
            next_cycle();
        end
        if (exp_stall > 255) exp_stall = 255;
        vga_req = 1'b0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        tests++; if ({cpu_ack, stall_cnt} !== {1'b1, 8'(exp_stall)}) begin fails++; $display("FAIL sat_ack2: ack=%b cnt=%0d exp 1 %0d", cpu_ack, stall_cnt, exp_stall); end
        next_cycle();
        cpu_req = 1'b0;
        next_cycle();
        shadow['h060] = 12'h606; shadow['h061] = 12'h616;
        $display("[TB] cpu wr 060=606, wr 061=616 (stall count saturated)");
    endtask

    task automatic test_random();
        bit            active = 1'b0;
        int            age = 0;
        bit            r_we = 1'b0;
        logic [AW-1:0] r_addr = '0;
        logic [DW-1:0] r_data = '0;
        bit            prev_vga = 1'b0;
        logic [DW-1:0] prev_exp = '0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            vga_req  = (cyc < 1500) ? 1'($urandom_range(1)) : 1'b0;
            vga_addr = 9'($urandom_range(511));
            if (!active && cyc < 1500 && $urandom_range(1) == 1) begin
                r_we = 1'($urandom_range(1)); r_addr = 9'('h40 + $urandom_range(7)); r_data = 12'($urandom_range(4095));
                cpu_req = 1'b1; cpu_we = r_we; cpu_addr = r_addr; cpu_wdata = r_data;
                active = 1'b1; age = 0;
            end
            @(negedge clk);
            if (vga_req) begin
                tests++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, vga_addr}) begin fails++; $display("FAIL rnd_vga_port[%0d]: en/we/addr=%b/%b/%h exp 1/0/%h", cyc, mem_en, mem_we, mem_addr, vga_addr); end
            end
            tests++; if (vga_rvalid !== prev_vga || (prev_vga && vga_rdata !== prev_exp)) begin fails++; $display("FAIL rnd_vga_data[%0d]: valid=%b data=%h exp %b %h", cyc, vga_rvalid, vga_rdata, prev_vga, prev_exp); end
            prev_vga = vga_req;
            prev_exp = ram[vga_addr];
            if (cpu_ack) begin
                tests++;
                if (!active) begin
                    fails++; $display("FAIL rnd_spurious_ack[%0d]: got 1 exp 0", cyc);
                end else begin
                    if (r_we) begin
                        shadow[r_addr] = r_data;
                    end else if (cpu_rdata !== shadow[r_addr]) begin
                        fails++; $display("FAIL rnd_rd[%0d]: addr=%h got %h exp %h", cyc, r_addr, cpu_rdata, shadow[r_addr]);
                    end
                    $display("[TB] cpu %s addr=%h data=%h", r_we ? "wr" : "rd", r_addr, r_we ? r_data : cpu_rdata);
                    active = 1'b0;
                end
            end else if (active) begin
                age++;
                if (age > 64) begin
                    tests++; fails++; $display("FAIL rnd_timeout[%0d]: no ack after %0d cycles exp <= 64", cyc, age);
                    active = 1'b0;
                end
            end
            next_cycle();
            if (!active) cpu_req = 1'b0;
        end
        tests++; if (active) begin fails++; $display("FAIL rnd_pending: request outstanding exp none"); end
        for (int j = 0; j < 8; j++) begin
            tests++; if (ram['h40 + j] !== shadow['h40 + j]) begin fails++; $display("FAIL rnd_ram[%h]: got %h exp %h", 'h40 + j, ram['h40 + j], shadow['h40 + j]); end
        end
        tests++; if (stall_cnt !== 8'(exp_stall)) begin fails++; $display("FAIL rnd_stall_sat: got %0d exp %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_reset_mid();
        int wr_before;
        bit got_ack = 1'b0;
        // Reset while a read sits in RD_ISSUED.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h031;
        @(negedge clk);
        tests++; if ({mem_en, mem_addr} !== {1'b1, 9'h031}) begin fails++; $display("FAIL rm_issue: en/addr=%b/%h exp 1/031", mem_en, mem_addr); end
        next_cycle();
        vga_req = 1'b1; vga_addr = 9'h007;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        tests++; if ({cpu_ack, vga_rvalid, wbuf_full, mem_en, mem_we} !== 5'b00000) begin fails++; $display("FAIL rm_flags: ack/rvalid/full/en/we=%b exp 00000", {cpu_ack, vga_rvalid, wbuf_full, mem_en, mem_we}); end
        tests++; if ({cpu_rdata, vga_rdata, stall_cnt} !== {12'h000, 12'h000, 8'd0}) begin fails++; $display("FAIL rm_data: rdata=%h vdata=%h cnt=%0d exp 000 000 0", cpu_rdata, vga_rdata, stall_cnt); end
        exp_stall = 0;
        cpu_req = 1'b0; vga_req = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        wr_before = wr_log_addr.size();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++; if (cpu_ack !== 1'b0) begin fails++; $display("FAIL rm_no_ack[%0d]: got %b exp 0", k, cpu_ack); end
            next_cycle();
        end
        // Reset while a posted write is still buffered behind display fetches.
        vga_req = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h050; cpu_wdata = 12'h777;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        tests++; if (cpu_ack !== 1'b1) begin fails++; $display("FAIL rm_wr_ack: got %b exp 1", cpu_ack); end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        tests++; if ({wbuf_full, mem_en, mem_we} !== 3'b000) begin fails++; $display("FAIL rm_wbuf: full/en/we=%b exp 000", {wbuf_full, mem_en, mem_we}); end
        vga_req = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++; if ({cpu_ack, mem_we} !== 2'b00) begin fails++; $display("FAIL rm_no_write[%0d]: ack/we=%b exp 00", k, {cpu_ack, mem_we}); end
            next_cycle();
        end
        tests++; if (wr_log_addr.size() != wr_before) begin fails++; $display("FAIL rm_ram_writes: got %0d exp 0", wr_log_addr.size() - wr_before); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h050;
        for (int k = 0; k < 6 && !got_ack; k++) begin
            @(negedge clk);
            if (cpu_ack) begin
                got_ack = 1'b1;
                tests++; if (cpu_rdata !== shadow['h050]) begin fails++; $display("FAIL rm_readback: got %h exp %h", cpu_rdata, shadow['h050]); end
            end
            next_cycle();
        end
        cpu_req = 1'b0;
        tests++; if (!got_ack) begin fails++; $display("FAIL rm_readback_ack: got none exp ack"); end
        $display("[TB] cpu rd 050 -> %h after discarded write", cpu_rdata);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) shadow[i] = init_word(i);
        test_reset();
        test_vga_burst();
        test_write_basic();
        test_write_stall();
        test_forward();
        test_read();
        test_stall_saturate();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
